// File: rtl/lobster_fetch_queue.sv
// Instruction fetch queue: issues sequential 8-byte bundle reads over req/ack,
// buffers returned bundles in a small FIFO, and presents them with their
// address on a valid/ready port. A redirect flushes the queue and restarts
// fetch; a request already on the bus is drained and its data dropped.
module lobster_fetch_queue #(
  parameter int                    ADDR_WIDTH = 36,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [63:0]           mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [63:0]           out_data,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [63:0]           data;
  } entry_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] disc_addr;  // address of the request being drained
  logic [CW-1:0]         count, count_nxt;
  logic [PW-1:0]         wptr, rptr;
  entry_t                mem [DEPTH];
  logic                  push, pop;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[2:0];

  assign mem_req   = (state == REQ) || (state == DISCARD);
  assign mem_addr  = (state == DISCARD) ? disc_addr : pc;
  assign fetch_pc  = pc;
  assign out_valid = (count != '0) && !redirect;
  assign out_addr  = (count != '0) ? mem[rptr].addr : '0;
  assign out_data  = (count != '0) ? mem[rptr].data : '0;
  assign push      = (state == REQ) && mem_ack && !redirect;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Next-state logic; a pop in IDLE only frees space for the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (redirect || count < FULL) state_nxt = REQ;
      end
      REQ: begin
        if (redirect)     state_nxt = mem_ack ? REQ : DISCARD;
        else if (mem_ack) state_nxt = (count_nxt < FULL) ? REQ : IDLE;
      end
      DISCARD: begin
        if (!redirect && mem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, fetch PC, occupancy and pointers; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      disc_addr <= '0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc    <= {redirect_pc[ADDR_WIDTH-1:3], 3'b000};
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
        if (state == REQ && !mem_ack) disc_addr <= pc;
      end else begin
        if (push) begin
          pc   <= pc + ADDR_WIDTH'(8);
          wptr <= wptr + PW'(1);
        end
        if (pop) rptr <= rptr + PW'(1);
        count <= count_nxt;
      end
    end
  end

  // FIFO storage; contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= '{addr: pc, data: mem_data};
  end

endmodule

// File: tb/tb_lobster_fetch_queue.sv
// Directed bench for lobster_fetch_queue. A second instance with a high
// RESET_PC shares the stimulus and is used for the address wrap check.
module tb_lobster_fetch_queue;

  localparam int AW = 36;
  localparam logic [AW-1:0] RP2 = 36'hF_FFFF_FFF0;

  logic          clk = 1'b0;
  logic          rst, mem_ack, redirect, out_ready;
  logic [AW-1:0] redirect_pc;
  logic          mem_req, out_valid;
  logic [AW-1:0] mem_addr, out_addr, fetch_pc;
  logic [63:0]   mem_data, out_data;
  logic          mem_req2, out_valid2;
  logic [AW-1:0] mem_addr2, out_addr2, fetch_pc2;
  logic [63:0]   mem_data2, out_data2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Memory model: bundle content is a fixed function of its address.
  function automatic logic [63:0] dm(input logic [AW-1:0] a);
    return {~a[27:0], a};
  endfunction

  assign mem_data  = dm(mem_addr);
  assign mem_data2 = dm(mem_addr2);

  lobster_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .fetch_pc(fetch_pc)
  );

  lobster_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(4), .RESET_PC(RP2)) dut_wrap (
    .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack), .mem_data(mem_data2), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .out_addr(out_addr2), .out_data(out_data2), .fetch_pc(fetch_pc2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8 && !mem_req; i++) step();
    chk("wait_req", 64'(mem_req), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int pushes, reqs;
    logic [AW-1:0] e;
    rst = 1'b1; mem_ack = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    step(); step();

    // Reset state
    chk("rst_req",   64'(mem_req),   64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_addr",  64'(out_addr),  64'(0));
    chk("rst_data",  out_data,       64'(0));
    chk("rst_pc",    64'(fetch_pc),  64'(0));
    chk("rst_pc2",   64'(fetch_pc2), 64'(RP2));
    rst = 1'b0;

    // Streaming: one request per cycle, output one cycle behind; wrap on dut_wrap
    wait_req();
    for (int k = 0; k < 6; k++) begin
      chk("stream_maddr", 64'(mem_addr), 64'(8 * k));
      e = RP2 + AW'(8 * k);
      chk("wrap_maddr", 64'(mem_addr2), 64'(e));
      if (k > 0) begin
        chk("stream_valid", 64'(out_valid), 64'(1));
        chk("stream_oaddr", 64'(out_addr), 64'(8 * (k - 1)));
        chk("stream_odata", out_data, dm(AW'(8 * (k - 1))));
      end
      step();
    end

    // Fill with no consumer: exactly four pushes, then idle
    rst = 1'b1; out_ready = 1'b0; step(); rst = 1'b0;
    wait_req();
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_ack) begin
        chk("fill_addr", 64'(mem_addr), 64'(8 * pushes));
        pushes++;
      end
      step();
    end
    chk("fill_cnt",   64'(pushes),    64'(4));
    chk("fill_req",   64'(mem_req),   64'(0));
    chk("fill_valid", 64'(out_valid), 64'(1));
    chk("fill_head",  64'(out_addr),  64'(0));

    // One pop frees one slot: exactly one new request for 0x20
    out_ready = 1'b1; step(); out_ready = 1'b0;
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req && mem_ack) begin
        chk("refill_addr", 64'(mem_addr), 64'(36'h20));
        reqs++;
      end
      step();
    end
    chk("refill_cnt",  64'(reqs),     64'(1));
    chk("refill_head", 64'(out_addr), 64'(8));

    // Redirect from IDLE with three entries queued
    mem_ack = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("rd1_idle",  64'(mem_req),   64'(0));
    chk("rd1_pre",   64'(out_valid), 64'(1));
    redirect = 1'b1; redirect_pc = 36'h1007;
    #1;
    chk("rd1_valid_now", 64'(out_valid), 64'(0));
    step(); redirect = 1'b0;
    chk("rd1_valid_next", 64'(out_valid), 64'(0));
    chk("rd1_req",   64'(mem_req),  64'(1));
    chk("rd1_maddr", 64'(mem_addr), 64'(36'h1000));
    chk("rd1_pc",    64'(fetch_pc), 64'(36'h1000));

    // Redirect while a request is pending: old request drained, data dropped
    redirect = 1'b1; redirect_pc = 36'h2000; step(); redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("disc_req",   64'(mem_req),   64'(1));
      chk("disc_maddr", 64'(mem_addr),  64'(36'h1000));
      chk("disc_pc",    64'(fetch_pc),  64'(36'h2000));
      chk("disc_valid", 64'(out_valid), 64'(0));
      step();
    end
    mem_ack = 1'b1; out_ready = 1'b1; step();
    chk("disc_drop",  64'(out_valid), 64'(0));
    chk("disc_next",  64'(mem_addr),  64'(36'h2000));
    step();
    chk("disc_valid2", 64'(out_valid), 64'(1));
    chk("disc_oaddr",  64'(out_addr),  64'(36'h2000));
    chk("disc_odata",  out_data,       dm(36'h2000));

    // Reset mid-request with two entries queued; ack in the reset cycle ignored
    rst = 1'b1; step(); rst = 1'b0; out_ready = 1'b0; mem_ack = 1'b1;
    wait_req();
    step(); step();
    chk("mid_valid", 64'(out_valid), 64'(1));
    chk("mid_maddr", 64'(mem_addr),  64'(36'h10));
    rst = 1'b1; step();
    chk("mid_rst_req",   64'(mem_req),   64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_pc",    64'(fetch_pc),  64'(0));
    chk("mid_rst_oaddr", 64'(out_addr),  64'(0));
    chk("mid_rst_odata", out_data,       64'(0));
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
